// File: rtl/speicher_arbiter_if.sv
// speicher_arbiter_if
//   Bundles every handshake and bus signal around the RAM arbiter: the SD loader
//   write port (L_*), the CPU instruction port (I_*), the CPU data port (D_*),
//   the single-port RAM (RAM_*), the Bildpuffer write port (BP_*), the button
//   inputs and the sticky error flag.
//   slave  : the arbiter's view (requests and RAM responses in, completions out)
//   master : the surrounding system's view (CPU, loader, RAM, Bildpuffer)
interface speicher_arbiter_if;
  logic        L_Schreiben;
  logic [31:0] L_Adresse;
  logic [31:0] L_Daten;
  logic        L_Fertig;

  logic        I_Lesen;
  logic [31:0] I_Adresse;
  logic [31:0] I_Daten;
  logic        I_Fertig;

  logic        D_Lesen;
  logic        D_Schreiben;
  logic [31:0] D_Adresse;
  logic [31:0] D_DatenRein;
  logic [31:0] D_DatenRaus;
  logic        D_Fertig;

  logic        RAM_LesenAn;
  logic        RAM_SchreibenAn;
  logic [31:0] RAM_Adresse;
  logic [31:0] RAM_DatenRein;
  logic [31:0] RAM_DatenRaus;
  logic        RAM_DatenBereit;
  logic        RAM_DatenGeschrieben;

  logic        BP_Write;
  logic [7:0]  BP_X;
  logic [7:0]  BP_Y;
  logic [7:0]  BP_Color;

  logic [6:0]  Buttons;
  logic        Fehler;

  modport slave (
    input  L_Schreiben, L_Adresse, L_Daten,
    input  I_Lesen, I_Adresse,
    input  D_Lesen, D_Schreiben, D_Adresse, D_DatenRein,
    input  RAM_DatenRaus, RAM_DatenBereit, RAM_DatenGeschrieben,
    input  Buttons,
    output L_Fertig, I_Daten, I_Fertig, D_DatenRaus, D_Fertig,
    output RAM_LesenAn, RAM_SchreibenAn, RAM_Adresse, RAM_DatenRein,
    output BP_Write, BP_X, BP_Y, BP_Color, Fehler
  );

  modport master (
    output L_Schreiben, L_Adresse, L_Daten,
    output I_Lesen, I_Adresse,
    output D_Lesen, D_Schreiben, D_Adresse, D_DatenRein,
    output RAM_DatenRaus, RAM_DatenBereit, RAM_DatenGeschrieben,
    output Buttons,
    input  L_Fertig, I_Daten, I_Fertig, D_DatenRaus, D_Fertig,
    input  RAM_LesenAn, RAM_SchreibenAn, RAM_Adresse, RAM_DatenRein,
    input  BP_Write, BP_X, BP_Y, BP_Color, Fehler
  );
endinterface

// File: rtl/speicher_arbiter.sv
// speicher_arbiter
//   Shares the single-port RAM between the SD loader, the CPU instruction port
//   and the CPU data port, and decodes the data port's MMIO space
//   (addr[31] = Bildpuffer write, addr[30] = button read).
//   Clock_i : system clock (CPU domain)
//   Reset_i : synchronous, active-high; aborts any transaction in flight
//   bus     : speicher_arbiter_if.slave, all request/response/RAM/MMIO signals
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   S_IDLE     | no transaction; arbitrate loader > round-robin(D, I)
//   S_RAM_WAIT | strobe held, waiting for RAM response or timeout
//   S_DONE     | strobe low, Fertig to the granted port, read data valid
//   S_MMIO     | data-port MMIO access completes (BP_Write / button read)
module speicher_arbiter #(
  parameter int unsigned RAM_ADDR_BITS = 15,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] ERR_WORD      = 32'hDEADBEEF
) (
  input logic               Clock_i,
  input logic               Reset_i,
  speicher_arbiter_if.slave bus
);

  localparam int unsigned    CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]    ADDR_MASK = 32'((64'd1 << RAM_ADDR_BITS) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RAM_WAIT, S_DONE, S_MMIO} state_t;
  typedef enum logic [1:0] {P_LOADER, P_INSTR, P_DATA} port_t;

  state_t           state_q, state_d;
  port_t            port_q, port_d;
  logic             rr_data_q, rr_data_d;   // 1: data port wins the next D/I tie
  logic             wr_q, wr_d;
  logic             rd_stb_q, rd_stb_d;
  logic             wr_stb_q, wr_stb_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      i_daten_q, i_daten_d;
  logic [31:0]      d_daten_q, d_daten_d;
  logic             bp_wr_q, bp_wr_d;
  logic [7:0]       bp_x_q, bp_x_d;
  logic [7:0]       bp_y_q, bp_y_d;
  logic [7:0]       bp_col_q, bp_col_d;
  logic             fehler_q, fehler_d;

  logic        d_req;
  logic        ram_resp;
  logic [31:0] rdata_sel;
  logic        unused_addr;

  assign d_req     = bus.D_Lesen | bus.D_Schreiben;
  assign ram_resp  = wr_q ? bus.RAM_DatenGeschrieben : bus.RAM_DatenBereit;
  // A real response wins over a timeout landing in the same cycle.
  assign rdata_sel = ram_resp ? bus.RAM_DatenRaus : ERR_WORD;
  // Upper address bits are intentionally ignored (RAM address wraps).
  assign unused_addr = ^{bus.L_Adresse, bus.I_Adresse, bus.D_Adresse};

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    rr_data_d = rr_data_q;
    wr_d      = wr_q;
    rd_stb_d  = rd_stb_q;
    wr_stb_d  = wr_stb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_daten_d = i_daten_q;
    d_daten_d = d_daten_q;
    bp_wr_d   = bp_wr_q;
    bp_x_d    = bp_x_q;
    bp_y_d    = bp_y_q;
    bp_col_d  = bp_col_q;
    fehler_d  = fehler_q;

    case (state_q)
      S_IDLE: begin
        if (bus.L_Schreiben) begin
          port_d   = P_LOADER;
          wr_d     = 1'b1;
          wr_stb_d = 1'b1;
          addr_d   = bus.L_Adresse & ADDR_MASK;
          wdata_d  = bus.L_Daten;
          cnt_d    = CNT_LOAD;
          state_d  = S_RAM_WAIT;
        end else if (d_req && (rr_data_q || !bus.I_Lesen)) begin
          port_d    = P_DATA;
          rr_data_d = 1'b0;
          if (bus.D_Adresse[31]) begin
            state_d = S_MMIO;
            bp_wr_d = bus.D_Schreiben;
            if (bus.D_Schreiben) begin
              bp_x_d   = bus.D_Adresse[15:8];
              bp_y_d   = bus.D_Adresse[7:0];
              bp_col_d = bus.D_DatenRein[7:0];
            end else begin
              d_daten_d = '0;
            end
          end else if (bus.D_Adresse[30]) begin
            // Button space is read-only; a write here completes without effect.
            state_d = S_MMIO;
            if (!bus.D_Schreiben) d_daten_d = {25'b0, bus.Buttons};
          end else begin
            // Write wins when both D_Lesen and D_Schreiben are set.
            state_d  = S_RAM_WAIT;
            wr_d     = bus.D_Schreiben;
            rd_stb_d = !bus.D_Schreiben;
            wr_stb_d = bus.D_Schreiben;
            addr_d   = bus.D_Adresse & ADDR_MASK;
            wdata_d  = bus.D_DatenRein;
            cnt_d    = CNT_LOAD;
          end
        end else if (bus.I_Lesen) begin
          port_d    = P_INSTR;
          rr_data_d = 1'b1;
          wr_d      = 1'b0;
          rd_stb_d  = 1'b1;
          addr_d    = bus.I_Adresse & ADDR_MASK;
          cnt_d     = CNT_LOAD;
          state_d   = S_RAM_WAIT;
        end
      end
      S_RAM_WAIT: begin
        if (ram_resp || cnt_q == '0) begin
          state_d  = S_DONE;
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
          if (!ram_resp) fehler_d = 1'b1;
          if (!wr_q) begin
            if (port_q == P_INSTR) i_daten_d = rdata_sel;
            else                   d_daten_d = rdata_sel;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_MMIO: begin
        state_d = S_IDLE;
        bp_wr_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q   <= S_IDLE;
      port_q    <= P_DATA;
      rr_data_q <= 1'b1;
      wr_q      <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_daten_q <= '0;
      d_daten_q <= '0;
      bp_wr_q   <= 1'b0;
      bp_x_q    <= '0;
      bp_y_q    <= '0;
      bp_col_q  <= '0;
      fehler_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      rr_data_q <= rr_data_d;
      wr_q      <= wr_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_daten_q <= i_daten_d;
      d_daten_q <= d_daten_d;
      bp_wr_q   <= bp_wr_d;
      bp_x_q    <= bp_x_d;
      bp_y_q    <= bp_y_d;
      bp_col_q  <= bp_col_d;
      fehler_q  <= fehler_d;
    end
  end

  assign bus.L_Fertig        = (state_q == S_DONE) && (port_q == P_LOADER);
  assign bus.I_Fertig        = (state_q == S_DONE) && (port_q == P_INSTR);
  assign bus.D_Fertig        = ((state_q == S_DONE) || (state_q == S_MMIO)) && (port_q == P_DATA);
  assign bus.I_Daten         = i_daten_q;
  assign bus.D_DatenRaus     = d_daten_q;
  assign bus.RAM_LesenAn     = rd_stb_q;
  assign bus.RAM_SchreibenAn = wr_stb_q;
  assign bus.RAM_Adresse     = addr_q;
  assign bus.RAM_DatenRein   = wdata_q;
  assign bus.BP_Write        = bp_wr_q && (state_q == S_MMIO);
  assign bus.BP_X            = bp_x_q;
  assign bus.BP_Y            = bp_y_q;
  assign bus.BP_Color        = bp_col_q;
  assign bus.Fehler          = fehler_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
module tb_speicher_arbiter;

  typedef struct {
    logic [1:0]  port;      // 0 loader, 1 instruction, 2 data
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [6:0]  btn;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_bp;
    logic [7:0]  bx;
    logic [7:0]  by;
    logic [7:0]  bc;
    int          exp_k;     // cycles from request to Fertig
    int          exp_stb;   // cycles with a RAM strobe high
    logic        exp_fehler;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  speicher_arbiter_if bus();

  speicher_arbiter #(
    .RAM_ADDR_BITS(15),
    .TIMEOUT(255),
    .ERR_WORD(32'hDEADBEEF)
  ) dut (
    .Clock_i(clk),
    .Reset_i(rst),
    .bus(bus.slave)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t mon_e;
  int   stb_cycles = 0;
  bit   ram_mute = 1'b0;
  logic [31:0] mem [0:255];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] port, input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [6:0] btn, input logic [31:0] exp_data,
                              input logic chk_data, input int exp_k, input int exp_stb);
    vec_t v;
    v.port = port; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.btn = btn;
    v.exp_data = exp_data; v.chk_data = chk_data; v.exp_bp = 1'b0;
    v.bx = 8'h00; v.by = 8'h00; v.bc = 8'h00;
    v.exp_k = exp_k; v.exp_stb = exp_stb; v.exp_fehler = 1'b0;
    return v;
  endfunction

  // RAM: answers one cycle after it first sees a strobe; silent when muted.
  always @(posedge clk) begin
    if (rst) begin
      bus.RAM_DatenBereit      <= 1'b0;
      bus.RAM_DatenGeschrieben <= 1'b0;
    end else begin
      bus.RAM_DatenBereit      <= bus.RAM_LesenAn && !bus.RAM_DatenBereit && !ram_mute;
      bus.RAM_DatenGeschrieben <= bus.RAM_SchreibenAn && !bus.RAM_DatenGeschrieben && !ram_mute;
      if (bus.RAM_LesenAn)
        bus.RAM_DatenRaus <= (bus.RAM_Adresse[31:8] == 24'h0) ? mem[bus.RAM_Adresse[7:0]] : 32'hBAD00000;
      if (bus.RAM_SchreibenAn && !bus.RAM_DatenGeschrieben && !ram_mute && bus.RAM_Adresse[31:8] == 24'h0)
        mem[bus.RAM_Adresse[7:0]] <= bus.RAM_DatenRein;
    end
  end

  always @(negedge clk) begin
    if (bus.RAM_LesenAn || bus.RAM_SchreibenAn) stb_cycles++;
  end

  // Scoreboard: every Fertig pops the oldest expected completion.
  always @(negedge clk) begin
    if (bus.L_Fertig || bus.I_Fertig || bus.D_Fertig) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_fertig: got L/I/D=%b%b%b expected none",
                 bus.L_Fertig, bus.I_Fertig, bus.D_Fertig);
      end else begin
        mon_e = sb.pop_front();
        chk("fertig_port", 32'({bus.L_Fertig, bus.I_Fertig, bus.D_Fertig}), 32'(3'b100 >> mon_e.port));
        chk("fehler", 32'(bus.Fehler), 32'(mon_e.exp_fehler));
        if (mon_e.chk_data) begin
          if (mon_e.port == 2'd1) chk("i_daten", bus.I_Daten, mon_e.exp_data);
          else                    chk("d_daten", bus.D_DatenRaus, mon_e.exp_data);
        end
        if (mon_e.port == 2'd2) begin
          chk("bp_write", 32'(bus.BP_Write), 32'(mon_e.exp_bp));
          if (mon_e.exp_bp)
            chk("bp_xyc", 32'({bus.BP_X, bus.BP_Y, bus.BP_Color}), 32'({mon_e.bx, mon_e.by, mon_e.bc}));
        end
      end
    end
    if (bus.BP_Write && !bus.D_Fertig) begin
      n_cmp++; n_bad++;
      $display("FAIL bp_stray: got BP_Write=1 expected 0 outside D_Fertig");
    end
  end

  task automatic wait_fert(input logic [2:0] mask, input int limit, output int k);
    k = 0;
    while (k < limit) begin
      @(negedge clk);
      if (({bus.L_Fertig, bus.I_Fertig, bus.D_Fertig} & mask) != 3'b000) break;
      k++;
    end
  endtask

  task automatic drop_all();
    bus.L_Schreiben = 1'b0;
    bus.I_Lesen     = 1'b0;
    bus.D_Lesen     = 1'b0;
    bus.D_Schreiben = 1'b0;
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_txn(input vec_t v);
    int k;
    int lim;
    case (v.port)
      2'd0: begin bus.L_Schreiben = 1'b1; bus.L_Adresse = v.addr; bus.L_Daten = v.wdata; end
      2'd1: begin bus.I_Lesen = 1'b1; bus.I_Adresse = v.addr; end
      default: begin
        bus.D_Lesen = v.rd; bus.D_Schreiben = v.wr;
        bus.D_Adresse = v.addr; bus.D_DatenRein = v.wdata;
      end
    endcase
    bus.Buttons = v.btn;
    sb.push_back(v);
    stb_cycles = 0;
    lim = v.exp_k + 20;
    wait_fert(3'b100 >> v.port, lim, k);
    chk("latency", 32'(k), 32'(v.exp_k));
    chk("strobe_cycles", 32'(stb_cycles), 32'(v.exp_stb));
    if (k >= lim && sb.size() > 0) void'(sb.pop_back());
    @(posedge clk); #1;
    drop_all();
  endtask

  vec_t tbl [15];
  vec_t tv;
  int   k;
  int   got;
  int   cyc;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | 32'(i);
    rst = 1'b1;
    drop_all();
    bus.L_Adresse = '0; bus.L_Daten = '0; bus.I_Adresse = '0;
    bus.D_Adresse = '0; bus.D_DatenRein = '0; bus.Buttons = '0;
    bus.RAM_DatenRaus = '0;

    tbl[0]  = mk(2, 1, 0, 32'h00000003, 32'hCAFE0003, 0, 0, 0, 3, 2);
    tbl[1]  = mk(2, 0, 1, 32'h00000003, 0, 0, 32'hCAFE0003, 1, 3, 2);
    tbl[2]  = mk(1, 0, 1, 32'h00000003, 0, 0, 32'hCAFE0003, 1, 3, 2);
    tbl[3]  = mk(0, 1, 0, 32'h00000007, 32'h55AA7777, 0, 0, 0, 3, 2);
    tbl[4]  = mk(1, 0, 1, 32'h00000007, 0, 0, 32'h55AA7777, 1, 3, 2);
    tbl[5]  = mk(1, 0, 1, 32'h00000040, 0, 0, 32'hA5000040, 1, 3, 2);
    tbl[6]  = mk(2, 0, 1, 32'h40000000, 0, 7'b1010011, 32'h00000053, 1, 1, 0);
    tbl[7]  = mk(2, 1, 0, 32'h80000A14, 32'hFFFFFF3C, 0, 0, 0, 1, 0);
    tbl[7].exp_bp = 1'b1; tbl[7].bx = 8'h0A; tbl[7].by = 8'h14; tbl[7].bc = 8'h3C;
    tbl[8]  = mk(2, 0, 1, 32'h80000000, 0, 7'h7F, 32'h00000000, 1, 1, 0);
    tbl[9]  = mk(2, 1, 0, 32'h40000004, 32'h00000099, 0, 0, 0, 1, 0);
    tbl[10] = mk(2, 0, 1, 32'h00000004, 0, 0, 32'hA5000004, 1, 3, 2);
    tbl[11] = mk(2, 0, 1, 32'h00008003, 0, 0, 32'hCAFE0003, 1, 3, 2);
    tbl[12] = mk(2, 1, 1, 32'h00000009, 32'h77770009, 0, 0, 0, 3, 2);
    tbl[13] = mk(2, 0, 1, 32'h00000009, 0, 0, 32'h77770009, 1, 3, 2);
    tbl[14] = mk(1, 0, 1, 32'h40000003, 0, 0, 32'hCAFE0003, 1, 3, 2);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", 32'({bus.RAM_LesenAn, bus.RAM_SchreibenAn}), 32'h0);
    chk("rst_fertig", 32'({bus.L_Fertig, bus.I_Fertig, bus.D_Fertig}), 32'h0);
    chk("rst_bp_write", 32'(bus.BP_Write), 32'h0);
    chk("rst_fehler", 32'(bus.Fehler), 32'h0);
    chk("rst_i_daten", bus.I_Daten, 32'h0);
    chk("rst_d_daten", bus.D_DatenRaus, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round robin: both CPU ports held from reset -> D, I, D, I
    bus.D_Lesen = 1'b1; bus.D_Adresse = 32'h10;
    bus.I_Lesen = 1'b1; bus.I_Adresse = 32'h20;
    sb.push_back(mk(2, 0, 1, 32'h10, 0, 0, 32'hA5000010, 1, 3, 2));
    sb.push_back(mk(1, 0, 1, 32'h20, 0, 0, 32'hA5000020, 1, 3, 2));
    sb.push_back(mk(2, 0, 1, 32'h10, 0, 0, 32'hA5000010, 1, 3, 2));
    sb.push_back(mk(1, 0, 1, 32'h20, 0, 0, 32'hA5000020, 1, 3, 2));
    got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      if (bus.L_Fertig || bus.I_Fertig || bus.D_Fertig) got++;
      cyc++;
    end
    chk("rr_grants", 32'(got), 32'd4);
    if (got < 4) sb.delete();
    @(posedge clk); #1;
    drop_all();

    // Loader priority over a simultaneous fetch of the same word
    bus.L_Schreiben = 1'b1; bus.L_Adresse = 32'h5; bus.L_Daten = 32'h12345678;
    bus.I_Lesen = 1'b1; bus.I_Adresse = 32'h5;
    sb.push_back(mk(0, 1, 0, 32'h5, 32'h12345678, 0, 0, 0, 3, 2));
    sb.push_back(mk(1, 0, 1, 32'h5, 0, 0, 32'h12345678, 1, 3, 2));
    wait_fert(3'b100, 20, k);
    chk("loader_first_lat", 32'(k), 32'd3);
    @(posedge clk); #1;
    bus.L_Schreiben = 1'b0;
    wait_fert(3'b010, 20, k);
    chk("fetch_after_loader_lat", 32'(k), 32'd3);
    if (k >= 20) sb.delete();
    @(posedge clk); #1;
    drop_all();

    for (int i = 0; i < 15; i++) run_txn(tbl[i]);

    // RAM never answers -> timeout completion
    ram_mute = 1'b1;
    tv = mk(2, 0, 1, 32'h22, 0, 0, 32'hDEADBEEF, 1, 256, 255);
    tv.exp_fehler = 1'b1;
    run_txn(tv);
    ram_mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("fehler_sticky", 32'(bus.Fehler), 32'h1);
    tv = mk(1, 0, 1, 32'h41, 0, 0, 32'hA5000041, 1, 3, 2);
    tv.exp_fehler = 1'b1;
    run_txn(tv);

    // Reset while waiting on the RAM aborts the transaction
    ram_mute = 1'b1;
    bus.D_Lesen = 1'b1; bus.D_Adresse = 32'h30;
    cyc = 0;
    while (!bus.RAM_LesenAn && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("strobe_before_reset", 32'(bus.RAM_LesenAn), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.D_Lesen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_strobes", 32'({bus.RAM_LesenAn, bus.RAM_SchreibenAn}), 32'h0);
    chk("abort_fehler", 32'(bus.Fehler), 32'h0);
    chk("abort_d_daten", bus.D_DatenRaus, 32'h0);
    ram_mute = 1'b0;
    wait_fert(3'b111, 10, k);
    chk("no_fertig_after_abort", 32'(k), 32'd10);
    @(posedge clk); #1;
    run_txn(mk(2, 0, 1, 32'h30, 0, 0, 32'hA5000030, 1, 3, 2));

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
